// File: rtl/img_proc_pkg.sv
// -----------------------------------------------------------------------------
// img_proc_pkg
// Shared definitions for the image-processing engine:
//   op_e          operation codes carried on op_sel
//   state_e       engine FSM states
//   KERN_*        sharpen kernel weights (centre / surrounding taps)
//   TAP_DR/TAP_DC 3x3 tap offset table, row-major from (-1,-1) to (+1,+1)
// -----------------------------------------------------------------------------
package img_proc_pkg;

  typedef enum logic [1:0] {
    OP_MIRROR  = 2'd0,
    OP_GRAY    = 2'd1,
    OP_SHARPEN = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    ACC  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam int KERN_CENTRE = 9;
  localparam int KERN_EDGE   = -1;

  localparam int NUM_TAPS   = 9;
  localparam int CENTRE_TAP = 4;

  typedef logic signed [1:0] tap_off_t;

  // Tap k sits at (TAP_DR[k], TAP_DC[k]) relative to the output pixel.
  localparam tap_off_t TAP_DR [NUM_TAPS] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,  2'sd0,  2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };
  localparam tap_off_t TAP_DC [NUM_TAPS] = '{
    -2'sd1,  2'sd0,  2'sd1,
    -2'sd1,  2'sd0,  2'sd1,
    -2'sd1,  2'sd0,  2'sd1
  };

endpackage

// File: rtl/img_proc_engine_sharpen_acc.sv
// -----------------------------------------------------------------------------
// sharpen_acc
// Signed accumulator for the 3x3 sharpen kernel, working on one channel.
//   clk, rst  clock and synchronous active-high reset
//   clr       zero the accumulator (wins over en)
//   en        add the weighted tap in g to the accumulator
//   mask      1 = tap lies inside the image; 0 = contribution forced to 0
//   centre    1 = centre tap (weight KERN_CENTRE), else weight KERN_EDGE
//   g         channel value of the tap
//   res       accumulator clamped to [0, 2**CH_W-1]
// -----------------------------------------------------------------------------
module sharpen_acc
  import img_proc_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic            mask,
  input  logic            centre,
  input  logic [CH_W-1:0] g,
  output logic [CH_W-1:0] res
);

  // 5 extra bits cover 9*max down to -8*max with a sign bit.
  localparam int AW = CH_W + 5;

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] g_s;
  logic signed [AW-1:0] weight;
  logic signed [AW-1:0] term;

  always_comb begin
    g_s    = $signed({5'b0, g});
    weight = centre ? AW'(KERN_CENTRE) : AW'(KERN_EDGE);
    term   = mask ? g_s * weight : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + term;
    end
  end

  // Negative -> 0; any bit set above the channel range -> saturate high.
  always_comb begin
    res = acc_q[CH_W-1:0];
    if (acc_q[AW-1]) begin
      res = '0;
    end else if (|acc_q[AW-2:CH_W]) begin
      res = '1;
    end
  end

endmodule

// File: rtl/img_proc_engine.sv
// -----------------------------------------------------------------------------
// img_proc_engine
// Runs one image operation per start (vertical mirror, grayscale, 3x3 sharpen)
// from a source memory with 1-cycle read latency into a destination memory,
// scanning row-major with the column as the inner index.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op_sel       1-cycle request and operation, taken only in IDLE
//   row, col            source read address (driven in RD)
//   in_pix              source data, valid the cycle after row/col
//   out_we/out_row/out_col/out_pix  destination write (only in WR)
//   busy                high in RD/ACC/WR
//   done                1-cycle pulse in FIN
//   mirror_done, gray_done, filter_done  sticky per-op completion flags
// Handshake: start is a single-cycle request with no ready; it is accepted
// only while the engine is idle and silently dropped otherwise. The source
// read has no valid/ready: data is assumed present one cycle after the address.
// -----------------------------------------------------------------------------
module img_proc_engine
  import img_proc_pkg::*;
#(
  parameter int ROW_W = 6,
  parameter int COL_W = 6,
  parameter int CH_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op_sel,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  input  logic [3*CH_W-1:0] in_pix,
  output logic              out_we,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic [3*CH_W-1:0] out_pix,
  output logic              busy,
  output logic              done,
  output logic              mirror_done,
  output logic              gray_done,
  output logic              filter_done
);

  localparam logic [ROW_W-1:0] ROW_LAST = '1;
  localparam logic [COL_W-1:0] COL_LAST = '1;

  state_e state_q, state_d;
  op_e    op_q;

  logic [ROW_W-1:0] r_q;
  logic [COL_W-1:0] c_q;
  logic [3:0]       tap_q;

  logic is_sharpen;
  logic last_pix;
  logic last_tap;

  // ---------------------------------------------------------------------------
  // Tap address: offset added in two extra bits so bit [W+1] is the sign and
  // bit [W] flags stepping past the last row/column.
  // ---------------------------------------------------------------------------
  tap_off_t         dr, dc;
  logic [ROW_W+1:0] tr;
  logic [COL_W+1:0] tc;
  logic [ROW_W-1:0] tap_row;
  logic [COL_W-1:0] tap_col;
  logic             tap_ok;
  logic             tap_ok_q;
  logic             tap_ctr_q;

  always_comb begin
    dr      = TAP_DR[tap_q];
    dc      = TAP_DC[tap_q];
    tr      = {2'b00, r_q} + {{ROW_W{dr[1]}}, dr};
    tc      = {2'b00, c_q} + {{COL_W{dc[1]}}, dc};
    tap_ok  = 1'b1;
    tap_row = tr[ROW_W-1:0];
    tap_col = tc[COL_W-1:0];
    if (tr[ROW_W+1]) begin
      tap_row = '0;
      tap_ok  = 1'b0;
    end else if (tr[ROW_W]) begin
      tap_row = ROW_LAST;
      tap_ok  = 1'b0;
    end
    if (tc[COL_W+1]) begin
      tap_col = '0;
      tap_ok  = 1'b0;
    end else if (tc[COL_W]) begin
      tap_col = COL_LAST;
      tap_ok  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Grayscale: midpoint of min and max channel, one extra bit for the sum.
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] ch_r, ch_g, ch_b;
  logic [CH_W-1:0] ch_min, ch_max;
  logic [CH_W:0]   gray_sum;
  logic [CH_W-1:0] gray_m;

  always_comb begin
    ch_r   = in_pix[2*CH_W +: CH_W];
    ch_g   = in_pix[CH_W +: CH_W];
    ch_b   = in_pix[0 +: CH_W];
    ch_min = ch_r;
    ch_max = ch_r;
    if (ch_g < ch_min) ch_min = ch_g;
    if (ch_b < ch_min) ch_min = ch_b;
    if (ch_g > ch_max) ch_max = ch_g;
    if (ch_b > ch_max) ch_max = ch_b;
    gray_sum = {1'b0, ch_min} + {1'b0, ch_max};
    gray_m   = gray_sum[CH_W:1];
  end

  // ---------------------------------------------------------------------------
  // Sharpen accumulator. Tap k-1 data arrives while tap k is issued, so the
  // mask/centre qualifiers are registered alongside the address.
  // ---------------------------------------------------------------------------
  logic            acc_clr;
  logic            acc_en;
  logic [CH_W-1:0] acc_res;

  sharpen_acc #(
    .CH_W (CH_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .mask   (tap_ok_q),
    .centre (tap_ctr_q),
    .g      (ch_g),
    .res    (acc_res)
  );

  assign is_sharpen = (op_q == OP_SHARPEN);
  assign last_pix   = (r_q == ROW_LAST) && (c_q == COL_LAST);
  assign last_tap   = (tap_q == 4'(NUM_TAPS - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    out_we  = 1'b0;
    row     = '0;
    col     = '0;
    out_row = '0;
    out_col = '0;
    out_pix = '0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (op_sel == OP_RSVD) ? FIN : RD;
        end
      end
      RD: begin
        busy = 1'b1;
        if (is_sharpen) begin
          row     = tap_row;
          col     = tap_col;
          acc_clr = (tap_q == 4'd0);
          acc_en  = (tap_q != 4'd0);
          if (last_tap) state_d = ACC;
        end else begin
          row     = (op_q == OP_MIRROR) ? (ROW_LAST - r_q) : r_q;
          col     = c_q;
          state_d = WR;
        end
      end
      ACC: begin
        busy    = 1'b1;
        acc_en  = 1'b1;
        state_d = WR;
      end
      WR: begin
        busy    = 1'b1;
        out_we  = 1'b1;
        out_row = r_q;
        out_col = c_q;
        case (op_q)
          OP_MIRROR:  out_pix = in_pix;
          OP_GRAY:    out_pix = {{CH_W{1'b0}}, gray_m, {CH_W{1'b0}}};
          OP_SHARPEN: out_pix = {{CH_W{1'b0}}, acc_res, {CH_W{1'b0}}};
          default:    out_pix = '0;
        endcase
        state_d = last_pix ? FIN : RD;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, latched op, tap qualifiers and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_MIRROR;
      r_q         <= '0;
      c_q         <= '0;
      tap_q       <= '0;
      tap_ok_q    <= 1'b0;
      tap_ctr_q   <= 1'b0;
      mirror_done <= 1'b0;
      gray_done   <= 1'b0;
      filter_done <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op_e'(op_sel);
            r_q   <= '0;
            c_q   <= '0;
            tap_q <= '0;
            case (op_sel)
              OP_MIRROR:  mirror_done <= 1'b0;
              OP_GRAY:    gray_done   <= 1'b0;
              OP_SHARPEN: filter_done <= 1'b0;
              default: ;
            endcase
          end
        end
        RD: begin
          if (is_sharpen) begin
            tap_ok_q  <= tap_ok;
            tap_ctr_q <= (tap_q == 4'(CENTRE_TAP));
            tap_q     <= last_tap ? 4'd0 : tap_q + 4'd1;
          end
        end
        WR: begin
          c_q <= c_q + 1'b1;
          if (c_q == COL_LAST) r_q <= r_q + 1'b1;
          // Flag rises together with the FIN cycle's done pulse.
          if (last_pix) begin
            case (op_q)
              OP_MIRROR:  mirror_done <= 1'b1;
              OP_GRAY:    gray_done   <= 1'b1;
              OP_SHARPEN: filter_done <= 1'b1;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_proc_engine.sv
// -----------------------------------------------------------------------------
// tb_img_proc_engine
// 4x4 image bench: behavioural source RAM with 1-cycle read latency, a write
// monitor checking every destination write against an expected queue, and a
// done-cycle measurement relative to the start cycle.
// -----------------------------------------------------------------------------
module tb_img_proc_engine;

  localparam int ROW_W = 2;
  localparam int COL_W = 2;
  localparam int CH_W  = 8;
  localparam int PW    = 3 * CH_W;
  localparam int N     = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [1:0]       op_sel;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [PW-1:0]    in_pix;
  logic             out_we;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [PW-1:0]    out_pix;
  logic             busy;
  logic             done;
  logic             mirror_done;
  logic             gray_done;
  logic             filter_done;

  img_proc_engine #(
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .CH_W  (CH_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_sel      (op_sel),
    .row         (row),
    .col         (col),
    .in_pix      (in_pix),
    .out_we      (out_we),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_pix     (out_pix),
    .busy        (busy),
    .done        (done),
    .mirror_done (mirror_done),
    .gray_done   (gray_done),
    .filter_done (filter_done)
  );

  // Source memory, 1-cycle read latency
  logic [PW-1:0] src_mem [N*N];
  always @(posedge clk) in_pix <= src_mem[{row, col}];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [ROW_W+COL_W+PW-1:0] exp_q[$];
  logic [ROW_W+COL_W+PW-1:0] exp_w;
  int wr_cnt   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {out_row, out_col, out_pix}, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("wr", {4'h0, out_row, out_col, out_pix}, {4'h0, exp_w});
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] gray_ref(input logic [PW-1:0] p);
    int r, g, b, mn, mx;
    r  = int'(p[23:16]);
    g  = int'(p[15:8]);
    b  = int'(p[7:0]);
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    return {8'h00, 8'((mn + mx) / 2), 8'h00};
  endfunction

  function automatic logic [PW-1:0] sharpen_ref(input int r, input int c);
    int acc, rr, cc, g;
    acc = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
          g = int'(src_mem[rr*N + cc][15:8]);
          acc += (dr == 0 && dc == 0) ? 9 * g : -g;
        end
      end
    end
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return {8'h00, 8'(acc), 8'h00};
  endfunction

  function automatic logic [ROW_W+COL_W+PW-1:0] pack_exp(input int r, input int c,
                                                          input logic [PW-1:0] p);
    return {2'(r), 2'(c), p};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Start is held for cycle 0; done_cyc is the cycle in which done is seen.
  // With poke set, start (with op_sel=sharpen) is also raised in cycles 5 and 20.
  task automatic run_op(input logic [1:0] op, input bit poke, output int done_cyc);
    int n;
    @(negedge clk);
    start  = 1'b1;
    op_sel = op;
    @(negedge clk);
    start    = 1'b0;
    n        = 1;
    done_cyc = -1;
    while (n <= 400) begin
      if (n == 1 && op != 2'd3) check("busy_cycle1", busy, 1);
      if (done === 1'b1) begin
        done_cyc = n;
        check("busy_at_done", busy, 0);
        break;
      end
      if (poke && (n == 5 || n == 20)) begin
        start  = 1'b1;
        op_sel = 2'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic push_mirror();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back(pack_exp(r, c, src_mem[(N-1-r)*N + c]));
  endtask

  task automatic push_gray();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back(pack_exp(r, c, gray_ref(src_mem[r*N + c])));
  endtask

  task automatic push_sharpen();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back(pack_exp(r, c, sharpen_ref(r, c)));
  endtask

  task automatic fill_random();
    for (int i = 0; i < N*N; i++) src_mem[i] = 24'($urandom_range(0, 24'hFF_FFFF));
  endtask

  // Let the write monitor settle, then confirm every expected write appeared.
  task automatic drain(input string tag, input int exp_wr);
    repeat (4) @(negedge clk);
    check({tag, "_wr_cnt"}, wr_cnt, exp_wr);
    check({tag, "_q_left"}, exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int dc;
  int d0, w0;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op_sel = 2'd0;
    for (int i = 0; i < N*N; i++) src_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {out_we, done, busy}, 0);
    check("rst_flags", {mirror_done, gray_done, filter_done}, 0);
    check("rst_addr", {row, col, out_row, out_col}, 0);
    check("rst_pix", out_pix, 0);
    rst = 1'b0;

    // Mirror: src(r,c) = {r, c, 5A}
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        src_mem[r*N + c] = {8'(r), 8'(c), 8'h5A};
    push_mirror();
    wr_cnt = 0;
    run_op(2'd0, 1'b0, dc);
    check("mirror_done_cyc", dc, 33);
    check("mirror_flag", mirror_done, 1);
    drain("mirror", 16);

    // Gray: three fixed corner cases, the rest random
    fill_random();
    src_mem[0] = 24'hFF8001;
    src_mem[1] = 24'hFFFFFF;
    src_mem[2] = 24'h000000;
    exp_q.push_back(pack_exp(0, 0, 24'h008000));
    exp_q.push_back(pack_exp(0, 1, 24'h00FF00));
    exp_q.push_back(pack_exp(0, 2, 24'h000000));
    for (int i = 3; i < N*N; i++) exp_q.push_back(pack_exp(i / N, i % N, gray_ref(src_mem[i])));
    wr_cnt = 0;
    run_op(2'd1, 1'b0, dc);
    check("gray_done_cyc", dc, 33);
    check("gray_flags", {mirror_done, gray_done, filter_done}, 3'b110);
    drain("gray", 16);

    // Sharpen on flat G=100 with random R/B
    for (int i = 0; i < N*N; i++)
      src_mem[i] = {8'($urandom_range(0, 255)), 8'd100, 8'($urandom_range(0, 255))};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (r == 0 && c == 0)      exp_q.push_back(pack_exp(r, c, 24'h00FF00));
        else if (r == 1 && c == 1) exp_q.push_back(pack_exp(r, c, 24'h006400));
        else                       exp_q.push_back(pack_exp(r, c, sharpen_ref(r, c)));
      end
    wr_cnt = 0;
    run_op(2'd2, 1'b0, dc);
    check("sharpen_done_cyc", dc, 177);
    check("sharpen_flag", filter_done, 1);
    drain("sharpen_flat", 16);

    // Sharpen: dark centre surrounded by saturated neighbours, rest random
    fill_random();
    for (int dr = 0; dr < 3; dr++)
      for (int dcl = 0; dcl < 3; dcl++)
        src_mem[dr*N + dcl][15:8] = 8'd255;
    src_mem[1*N + 1][15:8] = 8'd0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (r == 1 && c == 1) exp_q.push_back(pack_exp(r, c, 24'h000000));
        else                  exp_q.push_back(pack_exp(r, c, sharpen_ref(r, c)));
      end
    wr_cnt = 0;
    run_op(2'd2, 1'b0, dc);
    check("sharpen2_done_cyc", dc, 177);
    drain("sharpen_low", 16);

    // Mirror with start pulses during the run: both must be ignored
    push_mirror();
    wr_cnt = 0;
    d0 = done_cnt;
    run_op(2'd0, 1'b1, dc);
    check("busy_start_done_cyc", dc, 33);
    repeat (30) @(negedge clk);
    check("busy_start_done_cnt", done_cnt - d0, 1);
    check("busy_start_wr_cnt", wr_cnt, 16);
    check("busy_start_q_left", exp_q.size(), 0);

    // Reserved op: immediate done, no writes, flags untouched
    w0 = wr_cnt;
    run_op(2'd3, 1'b0, dc);
    check("rsvd_done_cyc", dc, 1);
    repeat (5) @(negedge clk);
    check("rsvd_writes", wr_cnt - w0, 0);
    check("rsvd_flags", {mirror_done, gray_done, filter_done}, 3'b111);

    // Reset in cycle 40 of a sharpen run
    fill_random();
    push_sharpen();
    wr_cnt = 0;
    @(negedge clk);
    start  = 1'b1;
    op_sel = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    d0  = done_cnt;
    @(negedge clk);
    check("abort_we", out_we, 0);
    check("abort_flags", {mirror_done, gray_done, filter_done}, 0);
    check("abort_busy", busy, 0);
    check("abort_wr_before", wr_cnt, 3);
    rst = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // Fresh gray after the abort
    fill_random();
    push_gray();
    wr_cnt = 0;
    run_op(2'd1, 1'b0, dc);
    check("regray_done_cyc", dc, 33);
    check("regray_flags", {mirror_done, gray_done, filter_done}, 3'b010);
    drain("regray", 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
